cache_axi_arbiter: RTL

Shares the single AXI master port of the CPU between the instruction-cache read port and the data-cache read and write ports. It serialises refill and uncached reads with round-robin arbitration and drives dirty-line writebacks and uncached stores through a separate write FSM. It holds data reads that hit a line still being written back (read-after-write), so dcache refills never return stale memory.

---
 rtl/cache_axi_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI master between icache reads and dcache reads/writes,
// round-robin read grant, independent write FSM, dcache reads held off lines still being written.
module cache_axi_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_rd_req,
  input  logic [2:0]               inst_rd_type,
  input  logic [ADDR_W-1:0]        inst_rd_addr,
  output logic                     inst_rd_rdy,
  output logic                     inst_ret_valid,
  output logic                     inst_ret_last,
  input  logic                     data_rd_req,
  input  logic [2:0]               data_rd_type,
  input  logic [ADDR_W-1:0]        data_rd_addr,
  output logic                     data_rd_rdy,
  output logic                     data_ret_valid,
  output logic                     data_ret_last,
  output logic [31:0]              ret_data,
  input  logic                     data_wr_req,
  input  logic [2:0]               data_wr_type,
  input  logic [ADDR_W-1:0]        data_wr_addr,
  input  logic [3:0]               data_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] data_wr_data,
  output logic                     data_wr_rdy,
  output logic [3:0]               arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
);
  localparam int BW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;
  function automatic logic [10:0] xfer(input logic [2:0] t);
    xfer = t == 3'b100 ? {8'(LINE_WORDS - 1), 3'd2} : {8'd0, 1'b0, t[1:0]};
  endfunction
  r_state_e                r_q, r_d;
  w_state_e                w_q, w_d;
  logic                    prio_q, prio_d, owner_q, owner_d;
  logic [ADDR_W-1:0]       raddr_q, raddr_d, waddr_q, waddr_d;
  logic [7:0]              rlen_q, rlen_d, wlen_q, wlen_d;
  logic [2:0]              rsize_q, rsize_d, wsize_q, wsize_d;
  logic [32*LINE_WORDS-1:0] wbuf_q, wbuf_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    wr_acc, raw, gnt_data, rd_acc, unused_ok;
  assign unused_ok = ^rid;
  assign data_wr_rdy = !reset && w_q == W_IDLE;
  assign wr_acc = data_wr_req && data_wr_rdy;
  // A refill must not overtake a writeback of the same line, including one accepted this cycle.
  assign raw = (w_q != W_IDLE && data_rd_addr[ADDR_W-1:4] == waddr_q[ADDR_W-1:4]) ||
               (wr_acc && data_rd_addr[ADDR_W-1:4] == data_wr_addr[ADDR_W-1:4]);
  assign gnt_data = data_rd_req && !raw && (!inst_rd_req || prio_q);
  assign inst_rd_rdy = !reset && r_q == R_IDLE && inst_rd_req && !gnt_data;
  assign data_rd_rdy = !reset && r_q == R_IDLE && gnt_data;
  assign rd_acc = inst_rd_rdy || data_rd_rdy;
  assign arid = {3'b0, owner_q};
  assign araddr = raddr_q;
  assign arlen = rlen_q;
  assign arsize = rsize_q;
  assign arvalid = r_q == R_AR;
  assign rready = r_q == R_DATA;
  assign inst_ret_valid = rready && rvalid && !owner_q;
  assign data_ret_valid = rready && rvalid && owner_q;
  assign inst_ret_last = inst_ret_valid && rlast;
  assign data_ret_last = data_ret_valid && rlast;
  assign ret_data = rdata;
  assign awaddr = waddr_q;
  assign awlen = wlen_q;
  assign awsize = wsize_q;
  assign awvalid = w_q == W_AW;
  assign wvalid = w_q == W_DATA;
  assign wdata = wbuf_q[32*beat_q +: 32];
  assign wstrb = wstrb_q;
  assign wlast = 8'(beat_q) == wlen_q;
  assign bready = w_q == W_RESP;
  always_comb begin
    r_d = r_q;
    prio_d = prio_q;
    owner_d = owner_q;
    raddr_d = raddr_q;
    {rlen_d, rsize_d} = {rlen_q, rsize_q};
    case (r_q)
      R_IDLE: if (rd_acc) begin
        r_d = R_AR;
        owner_d = data_rd_rdy;
        prio_d = !data_rd_rdy;
        raddr_d = data_rd_rdy ? data_rd_addr : inst_rd_addr;
        {rlen_d, rsize_d} = xfer(data_rd_rdy ? data_rd_type : inst_rd_type);
      end
      R_AR:    r_d = arready ? R_DATA : R_AR;
      R_DATA:  r_d = (rvalid && rlast) ? R_IDLE : R_DATA;
      default: r_d = R_IDLE;
    endcase
  end
  always_comb begin
    w_d = w_q;
    waddr_d = waddr_q;
    wbuf_d = wbuf_q;
    wstrb_d = wstrb_q;
    {wlen_d, wsize_d} = {wlen_q, wsize_q};
    beat_d = beat_q;
    case (w_q)
      W_IDLE: if (wr_acc) begin
        w_d = W_AW;
        waddr_d = data_wr_addr;
        wbuf_d = data_wr_data;
        wstrb_d = data_wr_type == 3'b100 ? 4'hf : data_wr_wstrb;
        {wlen_d, wsize_d} = xfer(data_wr_type);
        beat_d = '0;
      end
      W_AW: w_d = awready ? W_DATA : W_AW;
      W_DATA: if (wready) begin
        beat_d = beat_q + 1'b1;
        w_d = wlast ? W_RESP : W_DATA;
      end
      W_RESP:  w_d = bvalid ? W_IDLE : W_RESP;
      default: w_d = W_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    r_q <= reset ? R_IDLE : r_d;
    w_q <= reset ? W_IDLE : w_d;
    prio_q <= reset ? 1'b1 : prio_d;
    owner_q <= owner_d;
    raddr_q <= raddr_d;
    rlen_q <= rlen_d;
    rsize_q <= rsize_d;
    waddr_q <= waddr_d;
    wbuf_q <= wbuf_d;
    wstrb_q <= wstrb_d;
    wlen_q <= wlen_d;
    wsize_q <= wsize_d;
    beat_q <= beat_d;
  end
endmodule
